// File: rtl/rc4_pkg.sv
// ============================================================
// rc4_pkg : shared RC4 types, sizes and key-byte index helper
// Rev 1.0
// ============================================================
`default_nettype none

package rc4_pkg;

  localparam int KEY_LEN_DEFAULT = 3;
  localparam int S_SIZE          = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_WR,
    ST_INIT_LAST,
    ST_INIT_WAIT,
    ST_RD_I,
    ST_WAIT_I,
    ST_CAP_I,
    ST_CALC_J,
    ST_SWAP_REQ,
    ST_SWAP_WAIT,
    ST_NEXT,
    ST_DONE
  } ksa_state_t;

  function automatic logic [7:0] key_byte_index(input logic [7:0] idx,
                                                input int unsigned key_len);
    return 8'(32'(idx) % key_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_byte_sel.sv
// ============================================================
// key_byte_sel : picks key byte (idx mod KEY_LEN), byte 0 in the MSBs
// Rev 1.0
// ============================================================
`default_nettype none

module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [7:0]           idx,
  output logic [7:0]           key_byte
);

  logic [7:0] w_sel;

  always_comb begin
    w_sel    = key_byte_index(idx, KEY_LEN);
    key_byte = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (w_sel == 8'(k)) key_byte = secret_key[8*(KEY_LEN-1-k) +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ksa_ctrl.sv
// ============================================================
// ksa_ctrl : RC4 key-schedule controller, initiator of the swap handshake
// Optional S-memory identity fill: KSA_INIT_EN.  Rev 1.0
// ============================================================
`default_nettype none

module ksa_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           mem_address,
  output logic                 mem_wren,
  output logic [7:0]           mem_data,
  input  logic [7:0]           mem_q,
  output logic                 swap_owns_mem,
  output logic                 swap_flag,
  input  logic                 swap_done,
  output logic [7:0]           counter_i,
  output logic [7:0]           counter_j
);

  localparam logic [7:0] c_LAST_IDX = 8'(S_SIZE - 1);

  ksa_state_t r_state;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_s_i;
  logic [7:0] w_key_byte;

  key_byte_sel #(.KEY_LEN(KEY_LEN)) u_key_sel (
    .secret_key (secret_key),
    .idx        (r_i),
    .key_byte   (w_key_byte)
  );

`ifndef KSA_INIT_EN
  assign mem_wren = 1'b0;
  assign mem_data = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_i           <= 8'h00;
      r_j           <= 8'h00;
      r_s_i         <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_address   <= 8'h00;
      swap_flag     <= 1'b0;
      swap_owns_mem <= 1'b0;
      counter_i     <= 8'h00;
      counter_j     <= 8'h00;
`ifdef KSA_INIT_EN
      mem_wren      <= 1'b0;
      mem_data      <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i  <= 8'h00;
            r_j  <= 8'h00;
            busy <= 1'b1;
`ifdef KSA_INIT_EN
            r_state <= ST_INIT_WR;
`else
            r_state <= ST_RD_I;
`endif
          end
        end
`ifdef KSA_INIT_EN
        // r_i doubles as the fill address; it is cleared again before the schedule
        ST_INIT_WR: begin
          mem_wren    <= 1'b1;
          mem_address <= r_i;
          mem_data    <= r_i;
          if (r_i == c_LAST_IDX) r_state <= ST_INIT_LAST;
          else                   r_i     <= r_i + 8'd1;
        end
        ST_INIT_LAST: begin
          mem_wren <= 1'b0;
          mem_data <= 8'h00;
          r_i      <= 8'h00;
          r_state  <= ST_INIT_WAIT;
        end
        ST_INIT_WAIT: r_state <= ST_RD_I;
`endif
        ST_RD_I: begin
          mem_address <= r_i;
          r_state     <= ST_WAIT_I;
        end
        ST_WAIT_I: r_state <= ST_CAP_I;
        ST_CAP_I: begin
          r_s_i   <= mem_q;
          r_state <= ST_CALC_J;
        end
        ST_CALC_J: begin
          r_j     <= r_j + r_s_i + w_key_byte;
          r_state <= ST_SWAP_REQ;
        end
        ST_SWAP_REQ: begin
          counter_i     <= r_i;
          counter_j     <= r_j;
          swap_flag     <= 1'b1;
          swap_owns_mem <= 1'b1;
          r_state       <= ST_SWAP_WAIT;
        end
        // flag drops on the sampling edge so the engine cannot re-trigger
        ST_SWAP_WAIT: begin
          if (swap_done) begin
            swap_flag     <= 1'b0;
            swap_owns_mem <= 1'b0;
            r_state       <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_i == c_LAST_IDX) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_state <= ST_RD_I;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ksa_ctrl.sv
// ============================================================
// tb_ksa_ctrl : bench for ksa_ctrl with S-memory and swap-engine models
// Rev 1.0
// ============================================================
`default_nettype none

module tb_ksa_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic        busy, done, mem_wren, swap_owns_mem, swap_flag;
  logic [7:0]  mem_address, mem_data, mem_q, counter_i, counter_j;
  logic        swap_done, eng_done, spur_done;

  always #5 clk = ~clk;
  assign swap_done = eng_done | spur_done;

  ksa_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .secret_key    (secret_key),
    .busy          (busy),
    .done          (done),
    .mem_address   (mem_address),
    .mem_wren      (mem_wren),
    .mem_data      (mem_data),
    .mem_q         (mem_q),
    .swap_owns_mem (swap_owns_mem),
    .swap_flag     (swap_flag),
    .swap_done     (swap_done),
    .counter_i     (counter_i),
    .counter_j     (counter_j)
  );

  logic [7:0]  mem      [256];
  logic [7:0]  init_img [256];
  logic [7:0]  gold_s   [256];
  bit          load_img;
  int          eng_delay, eng_cnt, eng_phase, prev_phase;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          passes = 0, fails = 0, total = 0;
  int          rises = 0, done_cnt = 0, busy_bad = 0, flag_err = 0;
  logic        prev_flag = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // S-memory (one-cycle registered read) plus behavioural swap engine
  always @(posedge clk) mem_q <= mem[mem_address];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_phase <= 0;
      eng_cnt   <= 0;
      eng_done  <= 1'b0;
    end else begin
      if (load_img) begin
        for (int k = 0; k < 256; k++) mem[k] <= init_img[k];
      end else if (mem_wren && !swap_owns_mem) begin
        mem[mem_address] <= mem_data;
      end
      case (eng_phase)
        0: if (swap_flag) begin
          obs_q.push_back({counter_i, counter_j});
          if (exp_q.size() != 0)
            check("swap_ij", 32'({counter_i, counter_j}), 32'(exp_q.pop_front()));
          else
            check("sb_underflow", 32'({counter_i, counter_j}), 32'hFFFF_FFFF);
          eng_cnt   <= eng_delay;
          eng_phase <= 1;
        end
        1: if (eng_cnt <= 1) begin
          mem[counter_i] <= mem[counter_j];
          mem[counter_j] <= mem[counter_i];
          eng_done       <= 1'b1;
          eng_phase      <= 2;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
        default: begin
          eng_done  <= 1'b0;
          eng_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (swap_flag && !prev_flag) rises++;
    prev_flag = swap_flag;
    if (done) begin
      done_cnt++;
      if (busy) busy_bad++;
    end
    if ((eng_phase == 1 || eng_phase == 2) && !swap_flag) flag_err++;
    if (eng_phase == 0 && prev_phase == 2 && swap_flag) flag_err++;
    prev_phase = eng_phase;
  end

  // Golden RC4 KSA: fills exp_q with (i,j) pairs and gold_s with the final S
  task automatic gold(input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int k = 0; k < 256; k++) begin
`ifdef KSA_INIT_EN
      init_img[k] = 8'($urandom);
`else
      init_img[k] = 8'(k);
`endif
      gold_s[k] = 8'(k);
    end
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j  = j + gold_s[i] + kb;
      exp_q.push_back({8'(i), j});
      t         = gold_s[i];
      gold_s[i] = gold_s[j];
      gold_s[j] = t;
    end
  endtask

  task automatic load_and_start(input logic [23:0] key);
    secret_key = key;
    @(negedge clk) load_img = 1'b1;
    @(negedge clk) load_img = 1'b0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_ksa(input logic [23:0] key, input int delay, input string tag,
                         output int base);
    int r0, d0, b0, f0, n, budget, bad;
    eng_delay = delay;
    gold(key);
    r0 = rises; d0 = done_cnt; b0 = busy_bad; f0 = flag_err; base = obs_q.size();
    load_and_start(key);
    check({tag, "_busy"}, 32'(busy), 32'd1);
`ifdef KSA_INIT_EN
    n = 0;
    while (!swap_flag && n < 2000) begin @(negedge clk); n++; end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== 8'(k)) bad++;
    check({tag, "_init_fill"}, 32'(bad), 32'd0);
`endif
    budget = 256 * (delay + 12) + 1000;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_flag_rises"}, 32'(rises - r0), 32'd256);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_bad - b0), 32'd0);
    check({tag, "_handshake"}, 32'(flag_err - f0), 32'd0);
    check({tag, "_swaps"}, 32'(obs_q.size() - base), 32'd256);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold_s[k]) bad++;
    check({tag, "_final_s"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int base, n;
    logic [7:0] addr0;
    reset_n = 1'b0; start = 1'b0; spur_done = 1'b0; load_img = 1'b0;
    secret_key = 24'h0; eng_delay = 11; prev_phase = 0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({busy, done, mem_wren, swap_flag, swap_owns_mem}), 32'd0);
    check("rst_bus", {mem_address, mem_data, counter_i, counter_j}, 32'd0);
    reset_n = 1'b1;

    // abort a run while the swap at i=10 is outstanding
    gold(24'h010203);
    load_and_start(24'h010203);
    n = 0;
    while (!(swap_flag && counter_i == 8'd10) && n < 3000) begin @(negedge clk); n++; end
    check("midrst_reach_i10", 32'(n < 3000), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_ctl", 32'({busy, done, mem_wren, swap_flag, swap_owns_mem}), 32'd0);
    check("midrst_bus", {mem_address, mem_data, counter_i, counter_j}, 32'd0);
    exp_q.delete();
    @(negedge clk) reset_n = 1'b1;

    run_ksa(24'h010203, 11, "k010203", base);
    check("k010203_sw0", 32'(obs_q[base]),   32'h0001);
    check("k010203_sw1", 32'(obs_q[base+1]), 32'h0103);
    check("k010203_sw2", 32'(obs_q[base+2]), 32'h0208);

    // swap_done while idle must not move anything
    addr0 = mem_address;
    base  = obs_q.size();
    @(negedge clk) spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    repeat (5) @(negedge clk);
    check("spur_busy", 32'({busy, swap_flag, swap_owns_mem, done}), 32'd0);
    check("spur_addr", 32'(mem_address), 32'(addr0));
    check("spur_no_swap", 32'(obs_q.size() - base), 32'd0);

    run_ksa(24'h000000, 11, "k000000", base);
    check("k000000_self_swap", 32'(obs_q[base]), 32'h0000);

    run_ksa(24'h000249, 11, "k000249", base);
    run_ksa(24'h010203, 1,  "dly1",    base);
    run_ksa(24'h000249, 40, "dly40",   base);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
